// File: rtl/debouncer_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debouncer_mc_pkg
//  Description : Shared types for the multi-channel debouncer: per-channel
//                FSM state encoding and a level-decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package debouncer_mc_pkg;

    typedef enum logic [1:0] {
        ST_LO   = 2'b00,
        PEND_HI = 2'b01,
        ST_HI   = 2'b10,
        PEND_LO = 2'b11
    } deb_state_t;

    // Debounced level carried by a state: high while accepted-high or
    // while a fall is still only pending.
    function automatic logic level_of(input deb_state_t st);
        return (st == ST_HI) || (st == PEND_LO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debouncer_ch.sv
`default_nettype none
// ============================================================================
//  Module      : debouncer_ch
//  Description : One debouncer channel: 2-flop resynchronizer, four-state
//                counter FSM, registered level and optional edge pulses.
//                Edge pulses exist only when DEBOUNCER_MC_EDGE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module debouncer_ch
    import debouncer_mc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             din,
    input  logic [CNT_W-1:0] thr,
    output logic             dout,
    output logic             rise,
    output logic             fall
);

    localparam logic [CNT_W:0] c_cnt_one = {{CNT_W{1'b0}}, 1'b1};

    logic [1:0]       r_sync;
    logic             w_s;
    deb_state_t       r_state;
    deb_state_t       w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W:0]   w_cnt_inc;
    logic [CNT_W:0]   w_thr_eff;
    logic             w_hit;
    logic             r_dout;
    logic             w_dout_nx;

    // Two-flop resynchronizer bringing the raw input into the aclk domain.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], din};
        end
    end

    assign w_s = r_sync[1];

    // One extra bit keeps the increment from wrapping; a zero threshold
    // behaves as one so a change is always accepted eventually.
    assign w_cnt_inc = {1'b0, r_cnt} + c_cnt_one;
    assign w_thr_eff = (thr == '0) ? c_cnt_one : {1'b0, thr};
    assign w_hit     = (w_cnt_inc >= w_thr_eff);

    // Next-state and counter: a mismatch counts up, agreement cancels,
    // reaching the threshold accepts the new level and clears the count.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            ST_LO: begin
                w_cnt_nx = '0;
                if (w_s) begin
                    if (w_hit) begin
                        w_state_nx = ST_HI;
                    end else begin
                        w_state_nx = PEND_HI;
                        w_cnt_nx   = w_cnt_inc[CNT_W-1:0];
                    end
                end
            end
            PEND_HI: begin
                if (!w_s) begin
                    w_state_nx = ST_LO;
                    w_cnt_nx   = '0;
                end else if (w_hit) begin
                    w_state_nx = ST_HI;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx   = w_cnt_inc[CNT_W-1:0];
                end
            end
            ST_HI: begin
                w_cnt_nx = '0;
                if (!w_s) begin
                    if (w_hit) begin
                        w_state_nx = ST_LO;
                    end else begin
                        w_state_nx = PEND_LO;
                        w_cnt_nx   = w_cnt_inc[CNT_W-1:0];
                    end
                end
            end
            PEND_LO: begin
                if (w_s) begin
                    w_state_nx = ST_HI;
                    w_cnt_nx   = '0;
                end else if (w_hit) begin
                    w_state_nx = ST_LO;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx   = w_cnt_inc[CNT_W-1:0];
                end
            end
            default: begin
                w_state_nx = ST_LO;
                w_cnt_nx   = '0;
            end
        endcase
    end

    assign w_dout_nx = level_of(w_state_nx);

    // State, counter and debounced level registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_LO;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_dout  <= w_dout_nx;
        end
    end

    assign dout = r_dout;

`ifdef DEBOUNCER_MC_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Edge pulses registered alongside the level so they coincide with it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_dout_nx & ~r_dout;
            r_fall <= ~w_dout_nx & r_dout;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/debouncer_mc.sv
`default_nettype none
// ============================================================================
//  Module      : debouncer_mc
//  Description : Multi-channel counter-based debouncer. NCH independent
//                channels share one run-time stable-cycle threshold.
//                Define DEBOUNCER_MC_EDGE_EN to enable rise/fall pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module debouncer_mc
    import debouncer_mc_pkg::*;
#(
    parameter int NCH   = 8,
    parameter int CNT_W = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [NCH-1:0]   din,
    input  logic [CNT_W-1:0] thr,
    output logic [NCH-1:0]   dout,
    output logic [NCH-1:0]   rise,
    output logic [NCH-1:0]   fall
);

    // One fully independent channel per input bit.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        debouncer_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .aclk    (aclk),
            .aresetn (aresetn),
            .din     (din[g]),
            .thr     (thr),
            .dout    (dout[g]),
            .rise    (rise[g]),
            .fall    (fall[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_debouncer_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debouncer_mc
//  Description : Self-checking bench for debouncer_mc. Expected outputs are
//                queued when each cycle's stimulus is driven and compared
//                one clock later. Honours DEBOUNCER_MC_EDGE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debouncer_mc;

    localparam int NCH   = 8;
    localparam int CNT_W = 16;
`ifdef DEBOUNCER_MC_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic             aclk    = 1'b0;
    logic             aresetn = 1'b0;
    logic [NCH-1:0]   din     = '0;
    logic [CNT_W-1:0] thr     = 16'd4;
    logic [NCH-1:0]   dout;
    logic [NCH-1:0]   rise;
    logic [NCH-1:0]   fall;

    int n_cmp = 0;
    int n_bad = 0;

    // One table row: hold din/thr for n cycles, expecting these outputs
    // after every one of those cycles.
    typedef struct {
        logic [NCH-1:0]   din;
        logic [CNT_W-1:0] thr;
        int               n;
        logic [NCH-1:0]   dout;
        logic [NCH-1:0]   rise;
        logic [NCH-1:0]   fall;
    } vec_t;

    typedef struct {
        string            tag;
        logic [3*NCH-1:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    sb_t  e_chk;

    debouncer_mc #(
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .din     (din),
        .thr     (thr),
        .dout    (dout),
        .rise    (rise),
        .fall    (fall)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [3*NCH-1:0] act,
                         input logic [3*NCH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got dout/rise/fall=%h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [NCH-1:0] d, input logic [CNT_W-1:0] t,
                                input int n, input logic [NCH-1:0] ed,
                                input logic [NCH-1:0] er, input logic [NCH-1:0] ef);
        vec_t v;
        v.din = d; v.thr = t; v.n = n; v.dout = ed; v.rise = er; v.fall = ef;
        tbl.push_back(v);
    endfunction

    // Drive one row cycle by cycle, queuing the expected outputs.
    task automatic run(input logic [NCH-1:0] d, input logic [CNT_W-1:0] t,
                       input int n, input logic [NCH-1:0] ed,
                       input logic [NCH-1:0] er, input logic [NCH-1:0] ef,
                       input string tag);
        sb_t            e;
        logic [NCH-1:0] xr;
        logic [NCH-1:0] xf;
        xr = EDGE_EN ? er : '0;
        xf = EDGE_EN ? ef : '0;
        for (int k = 0; k < n; k++) begin
            @(negedge aclk);
            din   = d;
            thr   = t;
            e.tag = $sformatf("%s.c%0d", tag, k);
            e.exp = {ed, xr, xf};
            sb.push_back(e);
            @(posedge aclk);
        end
    endtask

    // Scoreboard consumer: compare just after each active edge.
    always @(posedge aclk) begin
        #1;
        if (sb.size() > 0) begin
            e_chk = sb.pop_front();
            check(e_chk.tag, {dout, rise, fall}, e_chk.exp);
        end
    end

    initial begin
        // Reset held with every input high: nothing may leak through.
        aresetn = 1'b0;
        din     = '1;
        thr     = 16'd4;
        repeat (3) @(negedge aclk);
        check("reset_hold", {dout, rise, fall}, '0);

        // Release mid-cycle; all channels accept after edge 6.
        @(posedge aclk);
        #2 aresetn = 1'b1;
        run(8'hFF, 16'd4, 5, 8'h00, 8'h00, 8'h00, "rst_rel");
        run(8'hFF, 16'd4, 1, 8'hFF, 8'hFF, 8'h00, "rst_rise");
        run(8'hFF, 16'd4, 2, 8'hFF, 8'h00, 8'h00, "rst_hold");

        // Asynchronous reset mid-operation clears outputs without a clock.
        @(negedge aclk);
        @(posedge aclk);
        #2 aresetn = 1'b0;
        #1 check("async_rst", {dout, rise, fall}, '0);
        din = '0;
        @(posedge aclk);
        #2 aresetn = 1'b1;
        run(8'h00, 16'd4, 6, 8'h00, 8'h00, 8'h00, "post_rst");

        // Basic rise and fall on ch0, thr=4.
        add(8'h01, 16'd4, 5, 8'h00, 8'h00, 8'h00);
        add(8'h01, 16'd4, 1, 8'h01, 8'h01, 8'h00);
        add(8'h01, 16'd4, 4, 8'h01, 8'h00, 8'h00);
        add(8'h00, 16'd4, 5, 8'h01, 8'h00, 8'h00);
        add(8'h00, 16'd4, 1, 8'h00, 8'h00, 8'h01);
        add(8'h00, 16'd4, 4, 8'h00, 8'h00, 8'h00);
        // ch1: 3-cycle glitch rejected, 4-cycle pulse accepted.
        add(8'h02, 16'd4, 3, 8'h00, 8'h00, 8'h00);
        add(8'h00, 16'd4, 8, 8'h00, 8'h00, 8'h00);
        add(8'h02, 16'd4, 4, 8'h00, 8'h00, 8'h00);
        add(8'h00, 16'd4, 1, 8'h00, 8'h00, 8'h00);
        add(8'h00, 16'd4, 1, 8'h02, 8'h02, 8'h00);
        add(8'h00, 16'd4, 3, 8'h02, 8'h00, 8'h00);
        add(8'h00, 16'd4, 1, 8'h00, 8'h00, 8'h02);
        add(8'h00, 16'd4, 4, 8'h00, 8'h00, 8'h00);
        // All channels together, ch3 only glitched for 2 cycles.
        add(8'hFF, 16'd4, 2, 8'h00, 8'h00, 8'h00);
        add(8'hF7, 16'd4, 3, 8'h00, 8'h00, 8'h00);
        add(8'hF7, 16'd4, 1, 8'hF7, 8'hF7, 8'h00);
        add(8'hF7, 16'd4, 3, 8'hF7, 8'h00, 8'h00);
        add(8'h00, 16'd4, 5, 8'hF7, 8'h00, 8'h00);
        add(8'h00, 16'd4, 1, 8'h00, 8'h00, 8'hF7);
        add(8'h00, 16'd4, 3, 8'h00, 8'h00, 8'h00);
        // thr=1: three-cycle latency.
        add(8'h10, 16'd1, 2, 8'h00, 8'h00, 8'h00);
        add(8'h10, 16'd1, 1, 8'h10, 8'h10, 8'h00);
        add(8'h10, 16'd1, 2, 8'h10, 8'h00, 8'h00);
        add(8'h00, 16'd1, 2, 8'h10, 8'h00, 8'h00);
        add(8'h00, 16'd1, 1, 8'h00, 8'h00, 8'h10);
        add(8'h00, 16'd1, 2, 8'h00, 8'h00, 8'h00);
        // thr=0 behaves exactly like thr=1.
        add(8'h10, 16'd0, 2, 8'h00, 8'h00, 8'h00);
        add(8'h10, 16'd0, 1, 8'h10, 8'h10, 8'h00);
        add(8'h10, 16'd0, 2, 8'h10, 8'h00, 8'h00);
        add(8'h00, 16'd0, 2, 8'h10, 8'h00, 8'h00);
        add(8'h00, 16'd0, 1, 8'h00, 8'h00, 8'h10);
        add(8'h00, 16'd0, 2, 8'h00, 8'h00, 8'h00);
        // thr=1: single-cycle pulse gives back-to-back rise then fall.
        add(8'h20, 16'd1, 1, 8'h00, 8'h00, 8'h00);
        add(8'h00, 16'd1, 1, 8'h00, 8'h00, 8'h00);
        add(8'h00, 16'd1, 1, 8'h20, 8'h20, 8'h00);
        add(8'h00, 16'd1, 1, 8'h00, 8'h00, 8'h20);
        add(8'h00, 16'd1, 2, 8'h00, 8'h00, 8'h00);
        // thr lowered 100 -> 2 with count at 50: accept on the next cycle.
        add(8'h10, 16'd100, 52, 8'h00, 8'h00, 8'h00);
        add(8'h10, 16'd2,    1, 8'h10, 8'h10, 8'h00);
        add(8'h10, 16'd2,    2, 8'h10, 8'h00, 8'h00);
        add(8'h00, 16'd2,    3, 8'h10, 8'h00, 8'h00);
        add(8'h00, 16'd2,    1, 8'h00, 8'h00, 8'h10);
        add(8'h00, 16'd2,    2, 8'h00, 8'h00, 8'h00);

        foreach (tbl[i]) begin
            run(tbl[i].din, tbl[i].thr, tbl[i].n, tbl[i].dout, tbl[i].rise,
                tbl[i].fall, $sformatf("vec%0d", i));
        end

        @(negedge aclk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending entries expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debouncer_mc.md
# debouncer_mc

Multi-channel, counter-based debouncer for slow external inputs such as buttons, interlocks and trigger lines. Each channel resynchronises its input into the `aclk` domain. A debounced level changes only after the resynced input has held its new value for a programmable number of consecutive cycles, and a one-cycle edge pulse marks each accepted change. The block sits between the board I/O and the control logic. It debounces both rising and falling edges, and the window is set at run time rather than by pipeline depth.

## Interface
- `NCH`, 8: number of independent channels (≥1).
- `CNT_W`, 16: width of the threshold and of each channel counter.
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset; asynchronous, active-low.
- `din`  in  NCH  raw asynchronous inputs, one bit per channel.
- `thr`  in  CNT_W  stable-cycle threshold, shared by all channels, quasi-static; 0 is treated as 1.
- `dout`  out  NCH  debounced levels.
- `rise`  out  NCH  one-cycle pulse coincident with `dout[i]` going 0→1.
- `fall`  out  NCH  one-cycle pulse coincident with `dout[i]` going 1→0.

## Operation
- **Resync:** per channel, a 2-flop synchronizer, reset to 0, produces `s[i]`.
- **Per-channel FSM:** states `ST_LO`, `PEND_HI`, `ST_HI`, `PEND_LO`; a `CNT_W` counter `cnt`.
- **`ST_LO`:**
  - `s=0`: stay, `cnt=0`.
  - `s=1`: go to `PEND_HI`, `cnt=1`.
- **`PEND_HI`:**
  - `s=0`: back to `ST_LO`, `cnt=0`.
  - `s=1`: `cnt+1`.
- **Transition to `ST_HI`:** when the next count would reach `thr`, i.e. `cnt+1 >= max(thr,1)`, enter `ST_HI`, clear `cnt`, set `dout=1` and pulse `rise` in the same registered cycle.
  - With `thr≤1` the FSM goes `ST_LO`→`ST_HI` directly on the first mismatch cycle, skipping `PEND_HI`.
- **`ST_HI`/`PEND_LO`:** mirror image of the above, pulsing `fall`.
- **Comparison is `>=`:** lowering `thr` below an in-flight count accepts the change on the next mismatch cycle. Raising `thr` extends the pending window.
- **Counter range:** the counter never exceeds `2^CNT_W-1`, so no wrap is possible. The maximum window is `2^CNT_W-1` cycles.
- **Channels are fully independent;** simultaneous edges on several channels are all handled in the same cycle.
- **`dout` derivation:** `dout[i]=1` in `ST_HI` and `PEND_LO`, 0 otherwise. `dout` is a registered output, not decoded combinationally from the state.

## Timing
- **Reset values:** all outputs reset to 0; all FSMs reset to `ST_LO`, counters to 0, synchronizer flops to 0.
- **Reset assertion:** mid-operation, it clears everything immediately, asynchronously.
- **Release:** synchronous to `aclk`; first evaluation on the first edge after release.
- **Latency:** `din` sampled high at edge 0 ⇒ `s` high after edge 2 ⇒ `dout`/`rise` high after edge `max(thr,1)+2`. Falling edges behave identically.
- **Glitch rejection:**
  - A pulse seen on `s` for fewer than `max(thr,1)` cycles never changes `dout`.
  - A pulse of exactly `thr` cycles is accepted.
- **Edge pulses:** `rise`/`fall` are high for exactly one cycle. They are never both high on one channel in one cycle.
- **`thr` timing:** sampled every cycle and is not retimed. Changes take effect on the next edge.

## Configuration
- **`DEBOUNCER_MC_EDGE_EN` defined:** `rise`/`fall` are generated as above.
- **`DEBOUNCER_MC_EDGE_EN` undefined:**
  - `rise`/`fall` are tied to 0 and their registers are not instantiated.
  - `dout` behaviour and latency are unchanged.

## Structure
- **Package `debouncer_mc_pkg`:** FSM state typedef `deb_state_t` (`ST_LO`, `PEND_HI`, `ST_HI`, `PEND_LO`), 2-bit encoding.
- **Sub-module `debouncer_ch`:** one channel.
  - Contents: synchronizer, FSM, counter, `dout`/`rise`/`fall` registers.
  - Parameter `CNT_W`; ports `aclk`, `aresetn`, `din`, `thr`, `dout`, `rise`, `fall`.
- **Top:** `debouncer_mc` instantiates `NCH` copies in a generate loop and concatenates outputs.

## Test plan
- **Reset:** hold `aresetn=0` with `din=all 1`, then release, `thr=4` → `dout=0` during reset; ch0 `dout=1` and `rise` pulse after edge 6 post-release.
- **Basic rise/fall:** `thr=4`, `din[0]` 0→1 at edge 0 → `dout[0]` rises after edge 6 with a 1-cycle `rise`. `din[0]` 1→0 at edge 20 → `dout[0]` falls after edge 26 with a 1-cycle `fall`.
- **Glitch rejection:** `thr=4`, `din[1]` high for 3 cycles → `dout[1]` stays 0, no pulses. Then high for 4 cycles → `dout[1]` rises, and falls 4 cycles after the input returns low.
- **Threshold edge cases:**
  - `thr=0` and `thr=1` → identical behaviour, `dout` follows `din` with 3-cycle latency.
  - `thr` lowered from 100 to 2 while `cnt=50` → accept on the next mismatch cycle.
- **Multi-channel independence:** `NCH=8`, all channels toggled in the same cycle, ch3 glitched → 7 simultaneous `rise` pulses; ch3 unchanged.
- **Config build:** without `DEBOUNCER_MC_EDGE_EN`, rerun the basic rise/fall test → `dout` timing identical, `rise`/`fall` constant 0.
